// File: rtl/ram_input_writer.sv
// ram_input_writer: unpacks a byte stream LSB-first into single-bit RAM writes with an auto-incrementing address.
// Latency: handshake at edge M -> ram_we high for cycles M+1..M+BYTE_WIDTH; one byte per BYTE_WIDTH+1 cycles sustained.
// Backpressure: in_ready only in LOAD with start low; optional ones_count port under RAM_WRITER_POPCOUNT_EN.
module ram_input_writer #(
    parameter int ADDR_WIDTH = 10,
    parameter int BYTE_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [BYTE_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic                  ram_data,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic                  ram_we,
    output logic                  busy,
`ifdef RAM_WRITER_POPCOUNT_EN
    output logic                  done,
    output logic [ADDR_WIDTH:0]   ones_count
`else
    output logic                  done
`endif
);

    localparam int CNT_W = (BYTE_WIDTH > 1) ? $clog2(BYTE_WIDTH) : 1;
    localparam logic [CNT_W-1:0]      LAST_BIT  = CNT_W'(BYTE_WIDTH - 1);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = {ADDR_WIDTH{1'b1}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_LOAD  = 2'd1,
        S_SHIFT = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [BYTE_WIDTH-1:0] r_shreg;
    logic [CNT_W-1:0]      r_bitcnt;

    logic w_in_ready;
    logic w_clr;     // start seen: restart the fill from address 0
    logic w_load;    // byte accepted into the shift register
    logic w_shift;   // one bit written this cycle

    // State register; reset and abort are handled through the next-state logic.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and datapath controls; start overrides everything else.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_clr       = 1'b0;
        w_load      = 1'b0;
        w_shift     = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            S_LOAD: begin
                w_in_ready = !start;
                if (start) begin
                    w_clr = 1'b1;
                end else if (in_valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_SHIFT;
                end
            end
            S_SHIFT: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_LOAD;
                end else begin
                    w_shift = 1'b1;
                    if (r_bitcnt == LAST_BIT) begin
                        w_state_nxt = (r_addr == LAST_ADDR) ? S_DONE : S_LOAD;
                    end
                end
            end
            S_DONE: begin
                if (start) begin
                    w_clr       = 1'b1;
                    w_state_nxt = S_LOAD;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Address, shift register and bit counter; a restart discards any partial byte.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_addr   <= '0;
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (w_clr) begin
            r_addr   <= '0;
            r_shreg  <= '0;
            r_bitcnt <= '0;
        end else if (w_load) begin
            r_shreg  <= in_data;
            r_bitcnt <= '0;
        end else if (w_shift) begin
            r_shreg  <= r_shreg >> 1;
            r_addr   <= r_addr + ADDR_WIDTH'(1);
            r_bitcnt <= r_bitcnt + CNT_W'(1);
        end
    end

`ifdef RAM_WRITER_POPCOUNT_EN
    logic [ADDR_WIDTH:0] r_ones;

    // Count ones actually written since the last start; frozen once the fill ends.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ones <= '0;
        end else if (w_clr) begin
            r_ones <= '0;
        end else if (w_shift && r_shreg[0]) begin
            r_ones <= r_ones + (ADDR_WIDTH + 1)'(1);
        end
    end

    assign ones_count = r_ones;
`endif

    // RAM port and status decode purely from registered state.
    assign ram_we   = (r_state == S_SHIFT);
    assign ram_data = (r_state == S_SHIFT) ? r_shreg[0] : 1'b0;
    assign ram_addr = r_addr;
    assign busy     = (r_state == S_LOAD) || (r_state == S_SHIFT);
    assign done     = (r_state == S_DONE);
    assign in_ready = w_in_ready;

endmodule

// File: tb/tb_ram_input_writer.sv
// tb_ram_input_writer: randomized stimulus against a bit-queue reference model of the fill.
// Checks every output every cycle on the falling edge, plus literal timing/content expectations.
// Build with RAM_WRITER_POPCOUNT_EN defined to also check ones_count.
module tb_ram_input_writer;

    localparam int AW    = 10;
    localparam int BW    = 8;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [BW-1:0] in_data = '0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic          ram_data;
    logic [AW-1:0] ram_addr;
    logic          ram_we;
    logic          busy;
    logic          done;
`ifdef RAM_WRITER_POPCOUNT_EN
    logic [AW:0]   ones_count;
`endif

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b1;

    ram_input_writer #(.ADDR_WIDTH(AW), .BYTE_WIDTH(BW)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .ram_data   (ram_data),
        .ram_addr   (ram_addr),
        .ram_we     (ram_we),
        .busy       (busy),
`ifdef RAM_WRITER_POPCOUNT_EN
        .done       (done),
        .ones_count (ones_count)
`else
        .done       (done)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: a fill is a queue of pending bits, written one per cycle
    // at consecutive addresses; a new byte is only taken when the queue is empty.
    bit m_active = 1'b0;
    bit m_done   = 1'b0;
    int m_addr   = 0;
    int m_ones   = 0;
    bit m_q[$];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_active = 1'b0;
            m_done   = 1'b0;
            m_addr   = 0;
            m_ones   = 0;
            m_q.delete();
        end else if (start) begin
            m_active = 1'b1;
            m_done   = 1'b0;
            m_addr   = 0;
            m_ones   = 0;
            m_q.delete();
        end else if (m_q.size() > 0) begin
            int wrote;
            wrote  = m_addr;
            m_ones = m_ones + int'(m_q[0]);
            void'(m_q.pop_front());
            m_addr = (m_addr + 1) % DEPTH;
            if (m_q.size() == 0 && wrote == DEPTH - 1) begin
                m_active = 1'b0;
                m_done   = 1'b1;
            end
        end else if (m_active && in_valid) begin
            for (int i = 0; i < BW; i++) m_q.push_back(in_data[i]);
        end
    end

    // Shadow of the RAM, filled from what the writer actually drives.
    bit shadow [DEPTH];
    always @(posedge clk) begin
        if (!rst && ram_we) shadow[ram_addr] <= ram_data;
    end

    // Per-cycle comparison of every output against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ram_we",   ram_we,   (m_q.size() > 0) ? 1 : 0);
            chk("ram_data", ram_data, (m_q.size() > 0) ? int'(m_q[0]) : 0);
            chk("ram_addr", ram_addr, m_addr);
            chk("busy",     busy,     m_active);
            chk("done",     done,     m_done);
            chk("in_ready", in_ready, (m_active && m_q.size() == 0 && !start) ? 1 : 0);
`ifdef RAM_WRITER_POPCOUNT_EN
            chk("ones_count", ones_count, m_ones);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        int     cnt;
        int     errs;
        bit     acc;
        bit     b;
        bit     found;
        logic [7:0] pat;

        // Reset, then in_valid without start must be ignored.
        in_valid = 1'b1;
        in_data  = 8'hFF;
        repeat (3) tick();
        chk("reset_ram_we", ram_we, 0);
        chk("reset_addr", ram_addr, 0);
        chk("reset_done", done, 0);
        rst = 1'b0;
        repeat (5) tick();
        chk("idle_in_ready", in_ready, 0);
        chk("idle_ram_we", ram_we, 0);
        chk("idle_busy", busy, 0);

        // Full fill with 0xA5 and in_valid held high: count edges from the start edge.
        in_data  = 8'hA5;
        in_valid = 1'b1;
        start    = 1'b1;
        tick();
        start = 1'b0;
        cnt   = 1;
        while (!done && cnt < 3000) begin
            tick();
            cnt++;
        end
        chk("a5_done_cycles", cnt, 1153);
        pat  = 8'hA5;
        errs = 0;
        for (int k = 0; k < DEPTH; k++) if (shadow[k] != pat[k % 8]) errs++;
        chk("a5_ram_pattern_errs", errs, 0);
`ifdef RAM_WRITER_POPCOUNT_EN
        chk("a5_ones_count", ones_count, 512);
`endif

        // Alternating 0x00/0xFF bytes with random in_valid gaps.
        in_valid = 1'b0;
        pulse_start();
        b   = 1'b0;
        cnt = 0;
        while (!done && cnt < 6000) begin
            in_valid = ($urandom_range(0, 2) != 0);
            in_data  = b ? 8'hFF : 8'h00;
            #1;
            acc = in_valid && in_ready;
            tick();
            if (acc) b = ~b;
            cnt++;
        end
        chk("gaps_done", done, 1);
        errs = 0;
        for (int k = 0; k < DEPTH; k++) if (shadow[k] != ((k / 8) % 2 == 1)) errs++;
        chk("gaps_ram_pattern_errs", errs, 0);
`ifdef RAM_WRITER_POPCOUNT_EN
        chk("gaps_ones_count", ones_count, 512);
`endif

        // Abort in the middle of byte 5 (address 44).
        in_valid = 1'b1;
        pulse_start();
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            in_data = 8'($urandom);
            if (ram_we && ram_addr == 10'd44) found = 1'b1;
            else tick();
        end
        chk("abort_reached_addr44", found, 1);
        pulse_start();
        chk("abort_we_drop", ram_we, 0);
        chk("abort_addr_clear", ram_addr, 0);
        chk("abort_busy", busy, 1);
        in_data = 8'h3C;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ram_we) found = 1'b1;
            else tick();
        end
        chk("abort_restart_write", found, 1);
        chk("abort_restart_addr", ram_addr, 0);
        chk("abort_restart_bit0", ram_data, 0);

        // start and in_valid together in LOAD: start wins, byte taken next cycle.
        in_valid = 1'b0;
        pulse_start();
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'h81;
        #1;
        chk("collide_in_ready", in_ready, 0);
        tick();
        start = 1'b0;
        #1;
        chk("collide_ready_after", in_ready, 1);
        tick();
        chk("collide_we", ram_we, 1);
        chk("collide_addr", ram_addr, 0);
        chk("collide_bit0", ram_data, 1);

        // Random bytes to completion, then in_valid in DONE is ignored.
        pulse_start();
        cnt = 0;
        while (!done && cnt < 1500) begin
            in_data = 8'($urandom);
            tick();
            cnt++;
        end
        chk("rand_done", done, 1);
        errs = 0;
        in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ram_we || !done) errs++;
        end
        chk("done_hold_errs", errs, 0);
        pulse_start();
        chk("restart_done", done, 0);
        chk("restart_busy", busy, 1);
        chk("restart_addr", ram_addr, 0);
`ifdef RAM_WRITER_POPCOUNT_EN
        chk("restart_ones", ones_count, 0);
`endif

        // Asynchronous reset in the middle of a byte.
        in_data = 8'hFF;
        found   = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            if (ram_we) found = 1'b1;
            else tick();
        end
        chk("rstmid_reached_write", found, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_we", ram_we, 0);
        chk("rstmid_busy", busy, 0);
        chk("rstmid_addr", ram_addr, 0);
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        repeat (3) tick();

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
